// File: rtl/mmio_dec.sv
// Memory-map decoder and MMIO register block between the MEM stage, the DMEM/IMEM
// block RAMs and the UART: store enables, IO registers, UART strobes and counters.
module mmio_dec #(
  parameter int          DATA_W    = 32,
  parameter int          CNT_W     = 32,
  parameter logic [3:0]  IO_REGION = 4'h8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              instr_retire,
  output logic [3:0]        dmem_we,
  output logic [3:0]        imem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              rd_sel,
  output logic [DATA_W-1:0] io_rdata,
  output logic              addr_err,
  input  logic              uart_din_ready,
  output logic              uart_din_valid,
  output logic [7:0]        uart_din,
  input  logic              uart_dout_valid,
  input  logic [7:0]        uart_dout,
  output logic              uart_dout_ready
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mmio_dec: DATA_W must be 32");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("mmio_dec: CNT_W must be in 1..32");
  end

  // IO register word offsets (byte offset / 4) within the IO region.
  localparam logic [25:0] OFF_STAT = 26'h0;
  localparam logic [25:0] OFF_RX   = 26'h1;
  localparam logic [25:0] OFF_TX   = 26'h2;
  localparam logic [25:0] OFF_CYC  = 26'h4;
  localparam logic [25:0] OFF_INS  = 26'h5;
  localparam logic [25:0] OFF_CLR  = 26'h6;

  logic [3:0]        region;
  logic [25:0]       word;
  logic              dmem_hit, imem_hit, io_hit, unmapped;
  logic              access, rw_both, misalign, err, wr_ok, rd_ok;
  logic [3:0]        be;
  logic [DATA_W-1:0] wrep;
  logic [DATA_W-1:0] io_word;
  logic [31:0]       cyc_ext, ins_ext;
  logic              clr, tx_fire, rx_pop;

  logic [CNT_W-1:0]  cyc_q, cyc_d, ins_q, ins_d;
  logic              rd_sel_q, rd_sel_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
  logic              addr_err_q, addr_err_d;
  logic              din_valid_q, din_valid_d;
  logic [7:0]        din_q, din_d;
  logic              dout_ready_q, dout_ready_d;

  assign region   = addr[31:28];
  assign word     = addr[27:2];
  assign dmem_hit = ~region[3] & region[0];
  assign imem_hit = ~region[3] & region[1];
  assign io_hit   = (region == IO_REGION);
  assign unmapped = ~(dmem_hit | imem_hit | io_hit);

  // Reset is folded in so that every output reads 0 while rst is high.
  assign access  = (mem_read | mem_write) & ~stall & ~rst;
  assign rw_both = mem_read & mem_write;

  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    wrep     = wdata;
    case (mem_size)
      2'b00: begin
        be   = 4'b0001 << addr[1:0];
        wrep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata[15:0]}};
        misalign = addr[0];
      end
      2'b10: begin
        be       = 4'b1111;
        misalign = |addr[1:0];
      end
      default: misalign = 1'b1;
    endcase
    if (misalign) be = 4'b0000;
  end

  assign err   = access & (misalign | unmapped | rw_both);
  assign wr_ok = access & ~err & mem_write;
  assign rd_ok = access & ~err & mem_read;

  assign dmem_we   = (wr_ok & dmem_hit) ? be : 4'b0000;
  assign imem_we   = (wr_ok & imem_hit) ? be : 4'b0000;
  assign mem_wdata = rst ? '0 : wrep;

  always_comb begin
    cyc_ext = '0;
    ins_ext = '0;
    cyc_ext[CNT_W-1:0] = cyc_q;
    ins_ext[CNT_W-1:0] = ins_q;
  end

  always_comb begin
    io_word = '0;
    if (io_hit) begin
      case (word)
        OFF_STAT: io_word = {30'b0, uart_dout_valid, uart_din_ready};
        OFF_RX:   io_word = {24'b0, uart_dout};
        OFF_CYC:  io_word = cyc_ext;
        OFF_INS:  io_word = ins_ext;
        default:  io_word = '0;
      endcase
    end
  end

  // UART handshake: a byte moves on a cycle where valid and ready are both high;
  // valid/ready strobes here are single-cycle, registered one cycle after the access.
  assign clr     = wr_ok & io_hit & (word == OFF_CLR);
  assign tx_fire = wr_ok & io_hit & (word == OFF_TX) & uart_din_ready;
  assign rx_pop  = rd_ok & io_hit & (word == OFF_RX);

  always_comb begin
    cyc_d        = clr ? '0 : cyc_q + CNT_W'(1);
    ins_d        = clr ? '0 : ins_q + CNT_W'(instr_retire);
    rd_sel_d     = rd_ok ? io_hit  : rd_sel_q;
    io_rdata_d   = rd_ok ? io_word : io_rdata_q;
    addr_err_d   = err;
    din_valid_d  = tx_fire;
    din_d        = tx_fire ? wdata[7:0] : 8'h00;
    dout_ready_d = rx_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q        <= '0;
      ins_q        <= '0;
      rd_sel_q     <= 1'b0;
      io_rdata_q   <= '0;
      addr_err_q   <= 1'b0;
      din_valid_q  <= 1'b0;
      din_q        <= 8'h00;
      dout_ready_q <= 1'b0;
    end else begin
      cyc_q        <= cyc_d;
      ins_q        <= ins_d;
      rd_sel_q     <= rd_sel_d;
      io_rdata_q   <= io_rdata_d;
      addr_err_q   <= addr_err_d;
      din_valid_q  <= din_valid_d;
      din_q        <= din_d;
      dout_ready_q <= dout_ready_d;
    end
  end

  assign rd_sel          = rd_sel_q;
  assign io_rdata        = io_rdata_q;
  assign addr_err        = addr_err_q;
  assign uart_din_valid  = din_valid_q;
  assign uart_din        = din_q;
  assign uart_dout_ready = dout_ready_q;

endmodule

// File: tb/tb_mmio_dec.sv
// Directed bench for mmio_dec: a default instance plus a CNT_W=4 instance sharing
// the same stimulus, so counter wrap is observed alongside the main checks.
`timescale 1ns/1ps
module tb_mmio_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, mem_write, mem_read, instr_retire;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic        uart_din_ready, uart_dout_valid;
  logic [7:0]  uart_dout;

  logic [3:0]  dmem_we, imem_we, d4_dmem_we, d4_imem_we;
  logic [31:0] mem_wdata, io_rdata, d4_mem_wdata, d4_io_rdata;
  logic        rd_sel, addr_err, uart_din_valid, uart_dout_ready;
  logic        d4_rd_sel, d4_addr_err, d4_uart_din_valid, d4_uart_dout_ready;
  logic [7:0]  uart_din, d4_uart_din;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_dec dut (
    .clk(clk), .rst(rst), .stall(stall), .mem_write(mem_write), .mem_read(mem_read),
    .mem_size(mem_size), .addr(addr), .wdata(wdata), .instr_retire(instr_retire),
    .dmem_we(dmem_we), .imem_we(imem_we), .mem_wdata(mem_wdata), .rd_sel(rd_sel),
    .io_rdata(io_rdata), .addr_err(addr_err), .uart_din_ready(uart_din_ready),
    .uart_din_valid(uart_din_valid), .uart_din(uart_din),
    .uart_dout_valid(uart_dout_valid), .uart_dout(uart_dout),
    .uart_dout_ready(uart_dout_ready)
  );

  mmio_dec #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .mem_write(mem_write), .mem_read(mem_read),
    .mem_size(mem_size), .addr(addr), .wdata(wdata), .instr_retire(instr_retire),
    .dmem_we(d4_dmem_we), .imem_we(d4_imem_we), .mem_wdata(d4_mem_wdata),
    .rd_sel(d4_rd_sel), .io_rdata(d4_io_rdata), .addr_err(d4_addr_err),
    .uart_din_ready(uart_din_ready), .uart_din_valid(d4_uart_din_valid),
    .uart_din(d4_uart_din), .uart_dout_valid(uart_dout_valid), .uart_dout(uart_dout),
    .uart_dout_ready(d4_uart_dout_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    mem_size = 2'b10; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic lw(input logic [31:0] a);
    stall = 1'b0; mem_write = 1'b0; mem_read = 1'b1; mem_size = 2'b10; addr = a;
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    stall = 1'b0; mem_write = 1'b1; mem_read = 1'b0; mem_size = sz; addr = a; wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr_retire = 1'b0;
    uart_din_ready = 1'b0; uart_dout_valid = 1'b0; uart_dout = 8'h00;
    idle();
    tick(); tick(); tick();
    chk("rst_rd_sel", rd_sel, 0);
    chk("rst_io_rdata", io_rdata, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_din_valid", uart_din_valid, 0);
    chk("rst_din", uart_din, 0);
    chk("rst_dout_ready", uart_dout_ready, 0);
    st(2'b10, 32'h1000_0000, 32'hFFFF_FFFF); #1;
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    idle();

    // Counters: 100 cycles out of reset, 40 retires.
    rst = 1'b0; instr_retire = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 40) instr_retire = 1'b0;
    end
    lw(32'h8000_0010); tick();
    chk("cyc_100", io_rdata, 100);
    chk("cyc_rd_sel", rd_sel, 1);
    chk("cyc4_wrap", d4_io_rdata, 100 % 16);
    lw(32'h8000_0014); tick();
    chk("ins_40", io_rdata, 40);
    chk("ins4_wrap", d4_io_rdata, 40 % 16);
    st(2'b10, 32'h8000_0018, 32'h0); instr_retire = 1'b1; tick();
    instr_retire = 1'b0;
    lw(32'h8000_0010); tick();
    chk("clr_cyc", io_rdata, 0);
    chk("clr_cyc4", d4_io_rdata, 0);
    lw(32'h8000_0014); tick();
    chk("clr_ins", io_rdata, 0);
    st(2'b10, 32'h8000_0018, 32'h0); stall = 1'b1; tick();
    lw(32'h8000_0010); tick();
    chk("stall_clr_ignored", io_rdata, 3);
    idle();

    // Stores to memory regions.
    st(2'b00, 32'h1000_0003, 32'h0000_00AB); #1;
    chk("sb_dmem_we", dmem_we, 4'b1000);
    chk("sb_imem_we", imem_we, 0);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    tick(); idle();
    chk("sb_err", addr_err, 0);
    st(2'b00, 32'h2000_0001, 32'h0000_007F); #1;
    chk("sb_imem_we", imem_we, 4'b0010);
    chk("sb_imem_dmem_we", dmem_we, 0);
    tick();
    st(2'b10, 32'h3000_0000, 32'h1234_5678); #1;
    chk("sw_dmem_we", dmem_we, 4'b1111);
    chk("sw_imem_we", imem_we, 4'b1111);
    chk("sw_wdata", mem_wdata, 32'h1234_5678);
    tick(); idle();
    chk("sw_err", addr_err, 0);
    st(2'b01, 32'h2000_0002, 32'h0000_BEEF); #1;
    chk("sh_imem_we", imem_we, 4'b1100);
    chk("sh_dmem_we", dmem_we, 0);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    tick();
    st(2'b01, 32'h1000_0001, 32'h0000_1234); #1;
    chk("mis_dmem_we", dmem_we, 0);
    chk("mis_imem_we", imem_we, 0);
    tick(); idle();
    chk("mis_err", addr_err, 1);
    tick();
    chk("mis_err_pulse", addr_err, 0);
    st(2'b11, 32'h1000_0000, 32'h0); #1;
    chk("size11_we", dmem_we, 0);
    tick(); idle();
    chk("size11_err", addr_err, 1);
    lw(32'h4000_0000); tick(); idle();
    chk("unmapped_err", addr_err, 1);
    st(2'b10, 32'h1000_0000, 32'h5); mem_read = 1'b1; #1;
    chk("rw_both_we", dmem_we, 0);
    tick(); idle();
    chk("rw_both_err", addr_err, 1);

    // IO reads.
    uart_din_ready = 1'b1; uart_dout_valid = 1'b1;
    lw(32'h8000_0000); tick(); idle();
    chk("stat_rd_sel", rd_sel, 1);
    chk("stat_rdata", io_rdata, 3);
    chk("stat_err", addr_err, 0);
    lw(32'h8000_0004); uart_dout = 8'h5A; tick(); idle();
    chk("rx_rdata", io_rdata, 32'h5A);
    chk("rx_ready", uart_dout_ready, 1);
    tick();
    chk("rx_ready_once", uart_dout_ready, 0);
    chk("rx_rdata_hold", io_rdata, 32'h5A);
    lw(32'h1000_0000); tick(); idle();
    chk("dmem_rd_sel", rd_sel, 0);

    // UART transmit.
    st(2'b10, 32'h8000_0008, 32'h141); tick(); idle();
    chk("tx_din", uart_din, 8'h41);
    chk("tx_valid", uart_din_valid, 1);
    tick();
    chk("tx_valid_once", uart_din_valid, 0);
    uart_din_ready = 1'b0;
    st(2'b10, 32'h8000_0008, 32'h141); tick(); idle();
    chk("tx_notready", uart_din_valid, 0);
    uart_din_ready = 1'b1;
    st(2'b10, 32'h8000_0008, 32'h141); stall = 1'b1; tick(); idle();
    chk("tx_stall", uart_din_valid, 0);
    st(2'b10, 32'h1000_0000, 32'h1); stall = 1'b1; #1;
    chk("stall_dmem_we", dmem_we, 0);
    idle();

    // Reset in the middle of an access.
    lw(32'h8000_0000); tick();
    chk("pre_rst_rdata", io_rdata, 3);
    lw(32'h8000_0004); rst = 1'b1; tick(); rst = 1'b0; idle();
    chk("midrst_rdata", io_rdata, 0);
    chk("midrst_rd_sel", rd_sel, 0);
    chk("midrst_dout_ready", uart_dout_ready, 0);
    st(2'b10, 32'h8000_0008, 32'h141); rst = 1'b1; tick(); rst = 1'b0; idle();
    chk("midrst_din_valid", uart_din_valid, 0);
    chk("midrst_din", uart_din, 0);
    lw(32'h8000_0010); tick(); idle();
    chk("midrst_cyc", io_rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
